// File: rtl/operand_skew_loader_if.sv
// ---------------------------------------------------------------------------
// operand_skew_loader_if
// Groups the control handshake, the global-buffer read port and the skewed
// operand output of one operand_skew_loader.
//   start/base_index/k_len : transfer request (base index and word count)
//   gb_index/gb_req        : read request to the global buffer
//   gb_data                : buffer read data, one cycle after gb_req
//   skew_out/skew_valid    : diagonal wavefront, one lane per PE row
//   busy/done              : transfer status and completion pulse
// The loader drives the buffer read port, so it takes the master modport.
// The surrounding system (buffer plus controller) takes the slave modport.
// ---------------------------------------------------------------------------
interface operand_skew_loader_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 8,
  parameter int WORD_W     = 32,
  parameter int IDX_W      = 16
) ();
  logic                  start;
  logic [IDX_W-1:0]      base_index;
  logic [IDX_W-1:0]      k_len;
  logic [IDX_W-1:0]      gb_index;
  logic                  gb_req;
  logic [WORD_W-1:0]     gb_data;
  logic [WORD_W-1:0]     skew_out;
  logic [ARRAY_SIZE-1:0] skew_valid;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, base_index, k_len, gb_data,
    output gb_index, gb_req, skew_out, skew_valid, busy, done
  );

  modport slave (
    output start, base_index, k_len, gb_data,
    input  gb_index, gb_req, skew_out, skew_valid, busy, done
  );
endinterface

// File: rtl/operand_skew_loader.sv
// ---------------------------------------------------------------------------
// operand_skew_loader
// Read-side consumer of a global buffer bank. A start request is registered
// and then streams K consecutive buffer words. Each word is split into
// ARRAY_SIZE byte lanes, and lane i is delayed by i cycles to form the
// diagonal wavefront that a systolic PE array edge expects.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : operand_skew_loader_if master modport (request, buffer read
//           port, skewed output, busy/done status)
// ---------------------------------------------------------------------------
module operand_skew_loader #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 8,
  parameter int WORD_W     = 32,
  parameter int IDX_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  operand_skew_loader_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_e;

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic [IDX_W-1:0] klen_q, klen_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             req_valid_q;

  logic [WORD_W-1:0]     skew_out_w;
  logic [ARRAY_SIZE-1:0] skew_valid_w;

  // The request is registered at the sampling edge, and the FSM acts on it
  // one edge later. This puts the first read in cycle 1. A request that is
  // already pending is never re-captured, so holding start high cannot
  // launch a second transfer.
  // cnt_q counts the remaining reads in READ. In DRAIN it counts the
  // cycles until the last lane has emitted its final element.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    base_d  = base_q;
    klen_d  = klen_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_q) begin
          if (klen_q != '0) begin
            state_d = READ;
            idx_d   = base_q;
            cnt_d   = klen_q;
          end else begin
            state_d = FIN;
          end
        end else if (bus.start) begin
          start_d = 1'b1;
          base_d  = bus.base_index;
          klen_d  = bus.k_len;
        end
      end
      READ: begin
        if (cnt_q == IDX_W'(1)) begin
          state_d = DRAIN;
          cnt_d   = IDX_W'(ARRAY_SIZE + 1);
        end else begin
          idx_d = idx_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == IDX_W'(1)) begin
          state_d = FIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers. req_valid_q follows gb_req one cycle late, which
  // matches the buffer's single-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      base_q      <= '0;
      klen_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      base_q      <= base_d;
      klen_q      <= klen_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      req_valid_q <= (state_q == READ);
    end
  end

  // Lane i is a chain of i+1 registers. Stage 0 captures the buffer word
  // slice, and zero is loaded when no read data is arriving. A lane that is
  // not valid therefore outputs 0 without an extra output mux.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_W-1:0] data_q [0:i];
    logic [i:0]        vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= i; j++) begin
          data_q[j] <= '0;
        end
        vld_q <= '0;
      end else begin
        data_q[0] <= req_valid_q ? bus.gb_data[i*DATA_W +: DATA_W] : '0;
        vld_q[0]  <= req_valid_q;
        for (int j = 1; j <= i; j++) begin
          data_q[j] <= data_q[j-1];
          vld_q[j]  <= vld_q[j-1];
        end
      end
    end

    assign skew_out_w[i*DATA_W +: DATA_W] = data_q[i];
    assign skew_valid_w[i]                = vld_q[i];
  end

  assign bus.gb_req     = (state_q == READ);
  assign bus.gb_index   = idx_q;
  assign bus.busy       = (state_q == READ) || (state_q == DRAIN);
  assign bus.done       = (state_q == FIN);
  assign bus.skew_out   = skew_out_w;
  assign bus.skew_valid = skew_valid_w;

endmodule

// File: tb/tb_operand_skew_loader.sv
// ---------------------------------------------------------------------------
// tb_operand_skew_loader
// Self-checking bench for operand_skew_loader. A behavioural global buffer
// answers reads one cycle after gb_req. Every cycle of every transfer is
// compared against a reference that derives each output from the transfer's
// timing rules: reads occur in cycles 1..K, the word read at cycle t reaches
// lane i at cycle t+2+i, and done is pulsed at K+ARRAY_SIZE+2.
// ---------------------------------------------------------------------------
module tb_operand_skew_loader;

  localparam int A  = 4;
  localparam int DW = 8;
  localparam int WW = 32;
  localparam int IW = 16;

  typedef struct {
    logic [IW-1:0] base;
    int            kLen;
    int            pulseAt;
    int            doneCycle;
  } vector_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  int checks = 0;
  int passed = 0;

  logic [WW-1:0] mem [0:65535];
  logic [IW-1:0] lastIdx = '0;

  operand_skew_loader_if #(.ARRAY_SIZE(A), .DATA_W(DW), .WORD_W(WW), .IDX_W(IW)) bus ();

  operand_skew_loader #(.ARRAY_SIZE(A), .DATA_W(DW), .WORD_W(WW), .IDX_W(IW)) dut (
    .clk   (clk),
    .rst_n (rstN),
    .bus   (bus)
  );

  // The clock runs with a 10-unit period.
  always #5 clk = ~clk;

  // The buffer model returns junk when no read is requested, so stale data
  // cannot pass unnoticed.
  always @(posedge clk) begin
    bus.gb_data <= bus.gb_req ? mem[bus.gb_index] : 32'hDEAD_BEEF;
  end

  // This task performs a single comparison.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
  endtask

  // This task holds the reference model for relative cycle n of a transfer
  // (base, k). A negative n means the loader is idle.
  task automatic applyStimulusCheck(input string tag, input logic [IW-1:0] base, input int k, input int n);
    logic          expReq;
    logic [IW-1:0] expIdx;
    logic [WW-1:0] expOut;
    logic [A-1:0]  expVld;
    logic          expBusy;
    logic          expDone;
    logic [WW-1:0] w;
    int            j;
    expReq = (n >= 1 && n <= k);
    expIdx = lastIdx;
    if (k > 0 && n >= 1) expIdx = base + IW'((n > k) ? k - 1 : n - 1);
    expOut = '0;
    expVld = '0;
    for (int i = 0; i < A; i++) begin
      j = n - 3 - i;
      if (j >= 0 && j < k) begin
        w = mem[base + IW'(j)];
        expOut[i*DW +: DW] = w[i*DW +: DW];
        expVld[i] = 1'b1;
      end
    end
    expBusy = (k > 0 && n >= 1 && n <= k + A + 1);
    expDone = (k == 0) ? (n == 1) : (n == k + A + 2);
    checkOutput($sformatf("%s c%0d gb_req", tag, n), 64'(bus.gb_req), 64'(expReq));
    checkOutput($sformatf("%s c%0d gb_index", tag, n), 64'(bus.gb_index), 64'(expIdx));
    checkOutput($sformatf("%s c%0d skew_out", tag, n), 64'(bus.skew_out), 64'(expOut));
    checkOutput($sformatf("%s c%0d skew_valid", tag, n), 64'(bus.skew_valid), 64'(expVld));
    checkOutput($sformatf("%s c%0d busy", tag, n), 64'(bus.busy), 64'(expBusy));
    checkOutput($sformatf("%s c%0d done", tag, n), 64'(bus.done), 64'(expDone));
  endtask

  // This task runs idle cycles with start low. The loader must stay quiet.
  task automatic idleCycles(input string tag, input int cnt);
    bus.start = 1'b0;
    for (int c = 0; c < cnt; c++) begin
      @(negedge clk);
      applyStimulusCheck(tag, '0, 0, -1);
    end
  endtask

  // This task runs one transfer and checks every cycle up to done. It is
  // entered and left at a negedge. fromDone=1 means that entry occurs in the
  // previous run's done cycle: start is then held across that cycle and the
  // following IDLE cycle. pulseAt raises a stray start during that cycle.
  // abortAt asserts reset in that cycle and abandons the run.
  task automatic checkTransfer(input string tag, input logic [IW-1:0] base, input int k,
                               input int pulseAt, input int abortAt, input bit fromDone,
                               output int doneAt);
    int last;
    doneAt = -1;
    last = (k == 0) ? 1 : k + A + 2;
    bus.start      = 1'b1;
    bus.base_index = base;
    bus.k_len      = IW'(k);
    if (fromDone) begin
      @(negedge clk);
      applyStimulusCheck(tag, base, k, -1);
    end
    @(negedge clk);
    bus.start      = 1'b0;
    bus.base_index = IW'($urandom);
    bus.k_len      = IW'($urandom_range(0, 20));
    for (int n = 0; n <= last; n++) begin
      if (n > 0) @(negedge clk);
      applyStimulusCheck(tag, base, k, n);
      if (bus.done === 1'b1) doneAt = n;
      bus.start = (n == pulseAt);
      if (n == abortAt) begin
        rstN    = 1'b0;
        lastIdx = '0;
        #1;
        applyStimulusCheck({tag, " rst"}, '0, 0, -1);
        for (int r = 0; r < 2; r++) begin
          @(negedge clk);
          applyStimulusCheck({tag, " rst"}, '0, 0, -1);
        end
        rstN = 1'b1;
        return;
      end
    end
    if (k > 0) lastIdx = base + IW'(k - 1);
  endtask

  vector_t vectors [5];

  initial begin
    int d;
    bit b2b;
    logic [IW-1:0] rBase;
    int rK;

    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[16] = 32'h0403_0201;
    mem[17] = 32'h0807_0605;
    mem[18] = 32'h0C0B_0A09;

    // Each vector record is {base, K, stray-start cycle, required done cycle}.
    vectors[0] = '{base: 16'd16,    kLen: 3,  pulseAt: -1, doneCycle: 9};
    vectors[1] = '{base: 16'd77,    kLen: 0,  pulseAt: -1, doneCycle: 1};
    vectors[2] = '{base: 16'hFFFE,  kLen: 4,  pulseAt: 3,  doneCycle: 10};
    vectors[3] = '{base: 16'd300,   kLen: 1,  pulseAt: -1, doneCycle: 7};
    vectors[4] = '{base: 16'hFFF8,  kLen: 16, pulseAt: 8,  doneCycle: 22};

    bus.start      = 1'b0;
    bus.base_index = '0;
    bus.k_len      = '0;

    // Reset is held for three cycles, then the loader must stay quiet.
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulusCheck("reset", '0, 0, -1);
    rstN = 1'b1;
    idleCycles("idle", 20);

    // The table-driven transfers cover basic skew, zero length, index wrap
    // and a stray start during a transfer.
    for (int v = 0; v < 5; v++) begin
      checkTransfer($sformatf("vec%0d", v), vectors[v].base, vectors[v].kLen,
                    vectors[v].pulseAt, -1, 1'b0, d);
      checkOutput($sformatf("vec%0d done cycle", v), 64'(d), 64'(vectors[v].doneCycle));
      idleCycles($sformatf("vec%0d tail", v), 2);
    end

    // Reset is applied in cycle 4 of a K=8 run, and a K=2 run follows
    // immediately after reset is released.
    checkTransfer("abort", 16'd40, 8, -1, 4, 1'b0, d);
    checkTransfer("postAbort", 16'd500, 2, -1, -1, 1'b0, d);
    checkOutput("postAbort done cycle", 64'(d), 64'(8));
    idleCycles("postAbort tail", 2);

    // Back to back: the next start is raised in the done cycle.
    checkTransfer("b2bA", 16'd1000, 5, -1, -1, 1'b0, d);
    checkOutput("b2bA done cycle", 64'(d), 64'(11));
    checkTransfer("b2bB", 16'd2000, 3, -1, -1, 1'b1, d);
    checkOutput("b2bB done cycle", 64'(d), 64'(9));
    idleCycles("b2b tail", 2);

    // Random transfers mix idle gaps, back-to-back starts and stray starts.
    for (int r = 0; r < 16; r++) begin
      rBase = IW'($urandom);
      rK    = $urandom_range(0, 10);
      b2b   = (r > 0) && ($urandom_range(0, 1) == 1);
      if (!b2b) idleCycles("rndGap", 1);
      checkTransfer($sformatf("rnd%0d", r), rBase, rK,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : -1, -1, b2b, d);
      checkOutput($sformatf("rnd%0d done cycle", r), 64'(d), 64'((rK == 0) ? 1 : rK + A + 2));
    end
    idleCycles("final", 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/operand_skew_loader.md
Name: operand_skew_loader

Overview:
- Read-side consumer of a global buffer bank.
- On a start pulse it issues K consecutive read indices to the buffer and captures the 1-cycle-latency read data.
- It slices each word into ARRAY_SIZE byte lanes and delays lane i by i cycles. This produces the diagonal (skewed) operand wavefront the systolic PE array needs.
- One instance feeds the weight edge of the array and one feeds the activation edge.

Parameters:
ARRAY_SIZE, 4, number of PE rows/lanes fed
DATA_W, 8, bits per lane element (signed, passed through unmodified)
WORD_W, 32, global buffer word width; must equal ARRAY_SIZE*DATA_W
IDX_W, 16, global buffer index width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted at 0)
start  input  1  one-cycle request to begin a transfer; sampled only in IDLE
base_index  input  IDX_W  first buffer index, sampled with start
k_len  input  IDX_W  number of words (columns) to stream, sampled with start
gb_index  output  IDX_W  read index to the global buffer
gb_req  output  1  high on cycles a read is issued; top level holds buffer wr_en=0 then
gb_data  input  WORD_W  global buffer data_out, valid one cycle after the request
skew_out  output  WORD_W  lane i = bits [i*DATA_W +: DATA_W], skewed
skew_valid  output  ARRAY_SIZE  per-lane valid
busy  output  1  transfer in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM to IDLE, all delay lines and counters cleared. Applies mid-transfer; the partial transfer is discarded and done is not pulsed.
- Timing reference: edge 0 is the clock edge that samples start=1 in IDLE; "cycle n" is the interval after edge n.
- FSM state IDLE:
  - start=1 and k_len>0: latch base_index and k_len, go to READ.
  - start=1 and k_len=0: go to FIN; no reads are issued and no lane is valid.
- FSM state READ:
  - Cycle 1+c, c=0..K-1: gb_req=1, gb_index=base+c.
  - Index addition wraps modulo 2^IDX_W.
  - After c=K-1, go to DRAIN.
- Read pipeline:
  - A 1-bit request-valid register tracks the buffer's 1-cycle read latency.
  - gb_data is captured when that register is set.
- Skew:
  - The word read in cycle t drives lane i of skew_out at cycle t+2+i, with skew_valid[i]=1.
  - Lane 0 is a single register stage; lane i has i extra stages.
  - Lanes not valid drive 0.
- FSM state DRAIN:
  - Hold until the last lane ARRAY_SIZE-1 data has been output, i.e. cycle K+1+ARRAY_SIZE. This uses a down-counter loaded with ARRAY_SIZE+1.
  - Then go to FIN.
- FSM state FIN: done=1 for exactly one cycle, busy=0, then IDLE.
  - For k_len>0, done is at cycle K+ARRAY_SIZE+2.
  - For k_len=0, done is at cycle 1.
- busy is 1 in READ and DRAIN, and 0 in IDLE and FIN.
- start while not IDLE is ignored; no queuing.
- start may be asserted in the same cycle done is high; it is accepted the next cycle (IDLE).
- gb_index holds its last value when gb_req=0. Its reset value is 0.
- No backpressure: the consumer must accept one wavefront per cycle.

Test Plan:
1. Reset/idle: rst=0 for 3 cycles, then release with start=0 -> all outputs 0 for 20 cycles, gb_req never 1.
2. Basic skew (ARRAY_SIZE=4), transfer parameters:
   - Inputs: base=16, K=3.
   - Buffer contents: [16]=0x04030201, [17]=0x08070605, [18]=0x0C0B0A09.
   - Required response:
     - gb_index 16,17,18 with gb_req=1 in cycles 1-3.
     - lane0 01,05,09 in cycles 3-5; lane1 02,06,0A in cycles 4-6; lane2 03,07,0B in cycles 5-7; lane3 04,08,0C in cycles 6-8.
     - busy cycles 1-8; done only in cycle 9.
3. Zero length: start with k_len=0 -> done at cycle 1, gb_req never 1, skew_valid stays 0.
4. Wrap and ignored start:
   - Stimulus: base=0xFFFE, K=4; pulse start again at cycle 3.
   - Required: indices FFFE,FFFF,0000,0001; second start has no effect; exactly one done, at cycle 10.
5. Reset mid-transfer, back-to-back:
   - Stimulus: rst=0 at cycle 4 of a K=8 run, released, then an immediate start with K=2.
   - Required: outputs cleared during reset; no done for the aborted run; the new run completes correctly with done at cycle 8.
6. Back-to-back: new start asserted in the done cycle -> second transfer's first read one cycle later; no lane data corrupted between runs.
